bmem_line_arbiter: RTL and testbench

Cache-line memory controller between the core's two L1 caches and the single burst memory port (`bmem_*`). It arbitrates round-robin between the instruction cache (port 0, read-only) and the data cache (port 1, read/write). Each granted request becomes a 4-beat, 64-bit burst on `bmem`. Read beats are assembled into a 256-bit line and returned with a one-cycle response pulse. One transaction is in flight at a time, and protocol violations are flagged on a sticky error output for the Verilator monitor.

---
 rtl/bmem_line_arbiter_if.sv | 40 ++++
 rtl/bmem_line_arbiter.sv | 138 +++++++++++++
 tb/tb_bmem_line_arbiter.sv | 289 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/bmem_line_arbiter_if.sv
// Signal bundle between the L1 caches, the line arbiter and the burst memory port.
// The master modport is the arbiter's view; slave is the surrounding caches/memory.
interface bmem_line_arbiter_if;
    logic [31:0]  p0_addr;
    logic         p0_read;
    logic         p0_resp;
    logic [255:0] p0_rdata;

    logic [31:0]  p1_addr;
    logic         p1_read;
    logic         p1_write;
    logic [255:0] p1_wdata;
    logic         p1_resp;
    logic [255:0] p1_rdata;

    logic [31:0]  bmem_addr;
    logic         bmem_read;
    logic         bmem_write;
    logic [63:0]  bmem_wdata;
    logic         bmem_ready;
    logic [31:0]  bmem_raddr;
    logic [63:0]  bmem_rdata;
    logic         bmem_rvalid;

    logic         err;

    modport master (
        input  p0_addr, p0_read, p1_addr, p1_read, p1_write, p1_wdata,
               bmem_ready, bmem_raddr, bmem_rdata, bmem_rvalid,
        output p0_resp, p0_rdata, p1_resp, p1_rdata,
               bmem_addr, bmem_read, bmem_write, bmem_wdata, err
    );

    modport slave (
        output p0_addr, p0_read, p1_addr, p1_read, p1_write, p1_wdata,
               bmem_ready, bmem_raddr, bmem_rdata, bmem_rvalid,
        input  p0_resp, p0_rdata, p1_resp, p1_rdata,
               bmem_addr, bmem_read, bmem_write, bmem_wdata, err
    );
endinterface

// File: rtl/bmem_line_arbiter.sv
// Round-robin icache/dcache arbiter onto a 4-beat x 64-bit burst memory port.
// One line transaction in flight; protocol violations latch a sticky err.
module bmem_line_arbiter (
    input  logic                clk,
    input  logic                rst,
    bmem_line_arbiter_if.master bus
);
    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_RD_ISSUE = 3'd1;
    localparam logic [2:0] S_RD_WAIT  = 3'd2;
    localparam logic [2:0] S_WR_BEAT  = 3'd3;
    localparam logic [2:0] S_RESP     = 3'd4;

    logic [2:0]       state_q, state_d;
    logic [1:0]       cnt_q, cnt_d;
    logic             ptr_q, ptr_d;     // last granted port
    logic             port_q, port_d;
    logic             wr_q, wr_d;
    logic [31:0]      addr_q, addr_d;
    logic [3:0][63:0] wdata_q, wdata_d;
    logic [3:0][63:0] line_q, line_d;
    logic             err_q, err_d;

    logic p0_req, p1_req, gnt;
    logic resp0, resp1;

    always_comb begin
        p0_req  = bus.p0_read;
        p1_req  = bus.p1_read | bus.p1_write;
        gnt     = (p0_req && p1_req) ? ~ptr_q : p1_req;

        state_d = state_q;
        cnt_d   = cnt_q;
        ptr_d   = ptr_q;
        port_d  = port_q;
        wr_d    = wr_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        line_d  = line_q;
        err_d   = err_q;

        case (state_q)
            S_IDLE: begin
                if (p0_req || p1_req) begin
                    port_d = gnt;
                    ptr_d  = gnt;
                    cnt_d  = 2'd0;
                    if (gnt) begin
                        addr_d = {bus.p1_addr[31:5], 5'b0};
                        wr_d   = bus.p1_write;
                        if (bus.p1_write) begin
                            wdata_d = bus.p1_wdata;
                            state_d = S_WR_BEAT;
                            if (bus.p1_read)
                                err_d = 1'b1;
                        end else begin
                            state_d = S_RD_ISSUE;
                        end
                    end else begin
                        addr_d  = {bus.p0_addr[31:5], 5'b0};
                        wr_d    = 1'b0;
                        state_d = S_RD_ISSUE;
                    end
                end
            end
            S_RD_ISSUE: begin
                if (bus.bmem_ready)
                    state_d = S_RD_WAIT;
            end
            S_RD_WAIT: begin
                // Beats tagged for another line are dropped, not stored.
                if (bus.bmem_rvalid) begin
                    if (bus.bmem_raddr == addr_q) begin
                        line_d[cnt_q] = bus.bmem_rdata;
                        cnt_d         = cnt_q + 2'd1;
                        if (cnt_q == 2'd3)
                            state_d = S_RESP;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            S_WR_BEAT: begin
                if (bus.bmem_ready) begin
                    cnt_d = cnt_q + 2'd1;
                    if (cnt_q == 2'd3)
                        state_d = S_RESP;
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (bus.bmem_rvalid && state_q != S_RD_WAIT)
            err_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= 2'd0;
            ptr_q   <= 1'b1;    // so the first contested grant goes to port 0
            port_q  <= 1'b0;
            wr_q    <= 1'b0;
            addr_q  <= 32'd0;
            wdata_q <= '0;
            line_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ptr_q   <= ptr_d;
            port_q  <= port_d;
            wr_q    <= wr_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            line_q  <= line_d;
            err_q   <= err_d;
        end
    end

    assign resp0 = (state_q == S_RESP) && !port_q;
    assign resp1 = (state_q == S_RESP) && port_q;

    assign bus.bmem_read  = (state_q == S_RD_ISSUE);
    assign bus.bmem_write = (state_q == S_WR_BEAT);
    assign bus.bmem_addr  = addr_q;
    assign bus.bmem_wdata = (state_q == S_WR_BEAT) ? wdata_q[cnt_q] : 64'd0;
    assign bus.p0_resp    = resp0;
    assign bus.p1_resp    = resp1;
    assign bus.p0_rdata   = resp0 ? line_q : '0;
    assign bus.p1_rdata   = (resp1 && !wr_q) ? line_q : '0;
    assign bus.err        = err_q;
endmodule

// File: tb/tb_bmem_line_arbiter.sv
// Directed bench for bmem_line_arbiter: a per-cycle vector table for the read,
// stalled-write and bad-tag cases, plus hand sequences for arbitration and reset.
module tb_bmem_line_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    bmem_line_arbiter_if bus();
    bmem_line_arbiter dut (.clk(clk), .rst(rst), .bus(bus));

    localparam logic [63:0] WA = 64'hA0A0_0000_0000_000A;
    localparam logic [63:0] WB = 64'hB0B0_0000_0000_000B;
    localparam logic [63:0] WC = 64'hC0C0_0000_0000_000C;
    localparam logic [63:0] WD = 64'hD0D0_0000_0000_000D;
    localparam logic [63:0] R0 = 64'h1111_1111_1111_1111;
    localparam logic [63:0] R1 = 64'h2222_2222_2222_2222;
    localparam logic [63:0] R2 = 64'h3333_3333_3333_3333;
    localparam logic [63:0] R3 = 64'h4444_4444_4444_4444;
    localparam logic [255:0] LINE_R = {R3, R2, R1, R0};

    typedef struct {
        string        nm;
        logic [2:0]   req;      // {p0_read, p1_read, p1_write}
        logic         ready;
        logic         rvalid;
        logic [31:0]  raddr;
        logic [63:0]  rdata;
        logic [1:0]   e_cmd;    // {bmem_read, bmem_write}
        logic [31:0]  e_addr;
        logic [63:0]  e_wdata;
        logic [2:0]   e_flags;  // {p0_resp, p1_resp, err}
        logic [255:0] e_line;
    } vec_t;

    vec_t tbl[$];
    int checks;
    int errors;
    int beats_left;
    logic [31:0] beat_addr;
    logic [3:0][63:0] wline;

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic add(input string nm, input logic [2:0] req, input logic rdy, input logic rv,
                       input logic [31:0] ra, input logic [63:0] rd, input logic [1:0] ecmd,
                       input logic [31:0] eaddr, input logic [63:0] ewd, input logic [2:0] efl,
                       input logic [255:0] eline);
        vec_t v;
        v.nm = nm; v.req = req; v.ready = rdy; v.rvalid = rv; v.raddr = ra; v.rdata = rd;
        v.e_cmd = ecmd; v.e_addr = eaddr; v.e_wdata = ewd; v.e_flags = efl; v.e_line = eline;
        tbl.push_back(v);
    endtask

    function automatic logic [255:0] exp_line(input logic [31:0] a);
        return {a, 32'd3, a, 32'd2, a, 32'd1, a, 32'd0};
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        bus.p0_read = 0; bus.p1_read = 0; bus.p1_write = 0;
        bus.bmem_ready = 0; bus.bmem_rvalid = 0; bus.bmem_raddr = 0; bus.bmem_rdata = 0;
        beats_left = 0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // One cycle with a well-behaved memory: always ready, four tagged beats after each read command.
    task automatic tick();
        @(negedge clk);
        bus.bmem_ready = 1'b1;
        if (beats_left > 0) begin
            bus.bmem_rvalid = 1'b1;
            bus.bmem_raddr  = beat_addr;
            bus.bmem_rdata  = {beat_addr, 32'(4 - beats_left)};
            beats_left--;
        end else begin
            bus.bmem_rvalid = 1'b0;
        end
        #1;
        if (bus.bmem_read) begin
            beats_left = 4;
            beat_addr  = bus.bmem_addr;
        end
    endtask

    // Run until a response, drop that port's request, and report which port answered.
    task automatic wait_resp(output int who);
        who = -1;
        for (int n = 0; n < 40 && who < 0; n++) begin
            tick();
            if (bus.p0_resp) begin
                who = 0;
                chk("p0 line", bus.p0_rdata, exp_line({bus.p0_addr[31:5], 5'b0}));
                bus.p0_read = 1'b0;
            end else if (bus.p1_resp) begin
                who = 1;
                if (!bus.p1_write)
                    chk("p1 line", bus.p1_rdata, exp_line({bus.p1_addr[31:5], 5'b0}));
                bus.p1_read = 1'b0;
                bus.p1_write = 1'b0;
            end
        end
        if (who < 0) begin
            checks++;
            errors++;
            $display("FAIL resp timeout: got no resp expected a resp within 40 cycles");
        end
    endtask

    initial begin
        int who;
        int nb;
        int rd_seen;
        int got;
        checks = 0;
        errors = 0;
        beats_left = 0;
        beat_addr = 0;
        bus.p0_addr = 0; bus.p1_addr = 0; bus.p1_wdata = 0;
        do_reset();
        #1;
        chk("reset bmem_read",  bus.bmem_read, 1'b0);
        chk("reset bmem_write", bus.bmem_write, 1'b0);
        chk("reset bmem_addr",  bus.bmem_addr, 32'd0);
        chk("reset bmem_wdata", bus.bmem_wdata, 64'd0);
        chk("reset resp",       {bus.p0_resp, bus.p1_resp}, 2'b00);
        chk("reset p0_rdata",   bus.p0_rdata, 256'd0);
        chk("reset p1_rdata",   bus.p1_rdata, 256'd0);
        chk("reset err",        bus.err, 1'b0);

        bus.p0_addr  = 32'h0000_1234;
        bus.p1_addr  = 32'h8000_0040;
        bus.p1_wdata = {WD, WC, WB, WA};

        // Port 0 read of 0x1234, beats on cycles 3,4,6,7 -> resp on cycle 8.
        add("rd c0", 3'b100, 1, 0, 0, 0,               2'b00, 32'h0,    0, 3'b000, 0);
        add("rd c1", 3'b100, 1, 0, 0, 0,               2'b10, 32'h1220, 0, 3'b000, 0);
        add("rd c2", 3'b100, 1, 0, 0, 0,               2'b00, 32'h1220, 0, 3'b000, 0);
        add("rd c3", 3'b100, 1, 1, 32'h1220, R0,       2'b00, 32'h1220, 0, 3'b000, 0);
        add("rd c4", 3'b100, 1, 1, 32'h1220, R1,       2'b00, 32'h1220, 0, 3'b000, 0);
        add("rd c5", 3'b100, 1, 0, 0, 0,               2'b00, 32'h1220, 0, 3'b000, 0);
        add("rd c6", 3'b100, 1, 1, 32'h1220, R2,       2'b00, 32'h1220, 0, 3'b000, 0);
        add("rd c7", 3'b100, 1, 1, 32'h1220, R3,       2'b00, 32'h1220, 0, 3'b000, 0);
        add("rd c8", 3'b100, 1, 0, 0, 0,               2'b00, 32'h1220, 0, 3'b100, LINE_R);
        add("rd c9", 3'b000, 1, 0, 0, 0,               2'b00, 32'h1220, 0, 3'b000, 0);
        // Port 1 write to 0x8000_0040 with ready low on cycle 2.
        add("wr c0", 3'b001, 1, 0, 0, 0, 2'b00, 32'h1220,      0,  3'b000, 0);
        add("wr c1", 3'b001, 1, 0, 0, 0, 2'b01, 32'h8000_0040, WA, 3'b000, 0);
        add("wr c2", 3'b001, 0, 0, 0, 0, 2'b01, 32'h8000_0040, WB, 3'b000, 0);
        add("wr c3", 3'b001, 1, 0, 0, 0, 2'b01, 32'h8000_0040, WB, 3'b000, 0);
        add("wr c4", 3'b001, 1, 0, 0, 0, 2'b01, 32'h8000_0040, WC, 3'b000, 0);
        add("wr c5", 3'b001, 1, 0, 0, 0, 2'b01, 32'h8000_0040, WD, 3'b000, 0);
        add("wr c6", 3'b001, 1, 0, 0, 0, 2'b00, 32'h8000_0040, 0,  3'b010, 0);
        add("wr c7", 3'b000, 1, 0, 0, 0, 2'b00, 32'h8000_0040, 0,  3'b000, 0);
        // Port 0 read with one wrongly tagged beat: dropped, err sticks.
        add("tag c0",  3'b100, 1, 0, 0, 0,                      2'b00, 32'h8000_0040, 0, 3'b000, 0);
        add("tag c1",  3'b100, 1, 0, 0, 0,                      2'b10, 32'h1220, 0, 3'b000, 0);
        add("tag c2",  3'b100, 1, 0, 0, 0,                      2'b00, 32'h1220, 0, 3'b000, 0);
        add("tag c3",  3'b100, 1, 1, 32'h2000, 64'hDEAD_BEEF,   2'b00, 32'h1220, 0, 3'b000, 0);
        add("tag c4",  3'b100, 1, 1, 32'h1220, R0,              2'b00, 32'h1220, 0, 3'b001, 0);
        add("tag c5",  3'b100, 1, 1, 32'h1220, R1,              2'b00, 32'h1220, 0, 3'b001, 0);
        add("tag c6",  3'b100, 1, 1, 32'h1220, R2,              2'b00, 32'h1220, 0, 3'b001, 0);
        add("tag c7",  3'b100, 1, 1, 32'h1220, R3,              2'b00, 32'h1220, 0, 3'b001, 0);
        add("tag c8",  3'b100, 1, 0, 0, 0,                      2'b00, 32'h1220, 0, 3'b101, LINE_R);
        add("tag c9",  3'b000, 1, 0, 0, 0,                      2'b00, 32'h1220, 0, 3'b001, 0);
        add("tag c10", 3'b000, 1, 0, 0, 0,                      2'b00, 32'h1220, 0, 3'b001, 0);

        foreach (tbl[i]) begin
            @(negedge clk);
            {bus.p0_read, bus.p1_read, bus.p1_write} = tbl[i].req;
            bus.bmem_ready  = tbl[i].ready;
            bus.bmem_rvalid = tbl[i].rvalid;
            bus.bmem_raddr  = tbl[i].raddr;
            bus.bmem_rdata  = tbl[i].rdata;
            #1;
            chk($sformatf("%s cmd", tbl[i].nm),   {bus.bmem_read, bus.bmem_write}, tbl[i].e_cmd);
            chk($sformatf("%s addr", tbl[i].nm),  bus.bmem_addr, tbl[i].e_addr);
            chk($sformatf("%s wdata", tbl[i].nm), bus.bmem_wdata, tbl[i].e_wdata);
            chk($sformatf("%s flags", tbl[i].nm), {bus.p0_resp, bus.p1_resp, bus.err}, tbl[i].e_flags);
            if (tbl[i].e_flags[2])
                chk($sformatf("%s p0_rdata", tbl[i].nm), bus.p0_rdata, tbl[i].e_line);
        end

        // Simultaneous requests after reset, then alternating re-requests.
        do_reset();
        bus.p0_addr = 32'h0000_0100;
        bus.p1_addr = 32'h0000_0200;
        bus.p0_read = 1'b1;
        bus.p1_read = 1'b1;
        for (int i = 0; i < 5; i++) begin
            wait_resp(who);
            chk($sformatf("alt grant %0d", i), who, i % 2);
            if (i < 3) begin
                tick();
                tick();
                if (who == 0) bus.p0_read = 1'b1;
                else          bus.p1_read = 1'b1;
            end
        end
        chk("alt err", bus.err, 1'b0);

        // Pointer: last grant was 0, so a contested request goes to 1.
        tick(); tick();
        bus.p0_read = 1'b1; bus.p1_read = 1'b1;
        wait_resp(who); chk("ptr both after 0", who, 1);
        wait_resp(who); chk("ptr drain 0", who, 0);
        tick(); tick();
        bus.p1_read = 1'b1;
        wait_resp(who); chk("ptr p1 alone", who, 1);
        tick(); tick();
        bus.p0_read = 1'b1; bus.p1_read = 1'b1;
        wait_resp(who); chk("ptr both after 1", who, 0);
        wait_resp(who); chk("ptr drain 1", who, 1);

        // Reset in RD_WAIT after two beats.
        do_reset();
        bus.p0_addr = 32'h0000_1234;
        bus.p0_read = 1'b1;
        for (int n = 0; n < 10 && beats_left != 2; n++)
            tick();
        chk("mid beats delivered", beats_left, 2);
        @(negedge clk);
        rst = 1'b1;
        bus.p0_read = 1'b0;
        bus.bmem_rvalid = 1'b0;
        beats_left = 0;
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("mid rst cmd",   {bus.bmem_read, bus.bmem_write}, 2'b00);
        chk("mid rst addr",  bus.bmem_addr, 32'd0);
        chk("mid rst wdata", bus.bmem_wdata, 64'd0);
        chk("mid rst flags", {bus.p0_resp, bus.p1_resp, bus.err}, 3'b000);
        chk("mid rst rdata", bus.p0_rdata, 256'd0);
        for (int n = 0; n < 3; n++) begin
            tick();
            chk($sformatf("mid no resp %0d", n), {bus.p0_resp, bus.p1_resp}, 2'b00);
        end
        bus.p0_read = 1'b1;
        wait_resp(who);
        chk("mid next read port", who, 0);
        chk("mid next read err", bus.err, 1'b0);
        // A stray beat while idle is a protocol error.
        @(negedge clk);
        bus.bmem_rvalid = 1'b1;
        bus.bmem_raddr  = 32'h0000_1220;
        @(negedge clk);
        bus.bmem_rvalid = 1'b0;
        #1;
        chk("idle rvalid err", bus.err, 1'b1);

        // Read and write together: write wins, err raised.
        do_reset();
        wline = {WD, WC, WB, WA};
        bus.p1_addr  = 32'h0000_0040;
        bus.p1_wdata = wline;
        bus.p1_read  = 1'b1;
        bus.p1_write = 1'b1;
        nb = 0; rd_seen = 0; got = 0;
        for (int n = 0; n < 20 && got == 0; n++) begin
            tick();
            if (bus.bmem_write) begin
                chk($sformatf("rw beat %0d", nb), bus.bmem_wdata, wline[nb[1:0]]);
                nb++;
            end
            if (bus.bmem_read) rd_seen++;
            if (bus.p1_resp) begin
                got = 1;
                bus.p1_read = 1'b0;
                bus.p1_write = 1'b0;
            end
        end
        chk("rw beats", nb, 4);
        chk("rw no read", rd_seen, 0);
        chk("rw resp", got, 1);
        chk("rw err", bus.err, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
